// File: rtl/unit_test_sequencer_pkg.sv
// Shared types for the unit-test sequencer: FSM state encodings and a small
// index-to-one-hot helper used to drive the launch vector.
package unit_test_sequencer_pkg;

    localparam int SEQ_ST_W = 3;

    typedef enum logic [SEQ_ST_W-1:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_LAUNCH = 3'd1,
        SEQ_WAIT   = 3'd2,
        SEQ_NEXT   = 3'd3,
        SEQ_DONE   = 3'd4
    } seq_state_e;

    // One-hot of a test index; callers truncate to their N_TESTS width.
    function automatic logic [31:0] f_onehot(input logic [4:0] idx);
        logic [31:0] v;
        v = 32'd1 << idx;
        return v;
    endfunction

endpackage

// File: rtl/unit_test_sequencer_sync_2ff.sv
// Two-stage synchroniser bank for level inputs crossing into the clk domain.
// Both stages clear asynchronously with rst_n.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/unit_test_sequencer.sv
// Initiator of the start/finish unit-test handshake: launches each responder
// in index order, waits for its finish or a timeout, and records the outcome.
module unit_test_sequencer
    import unit_test_sequencer_pkg::*;
#(
    parameter int N_TESTS        = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W = ($clog2(N_TESTS) > 0) ? $clog2(N_TESTS) : 1,
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic [N_TESTS-1:0] finish,
    output logic [N_TESTS-1:0] start,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   cur_idx,
    output logic [N_TESTS-1:0] ok_mask,
    output logic [N_TESTS-1:0] timeout_mask
);

    seq_state_e         r_state;
    logic [N_TESTS-1:0] r_start;
    logic               r_busy;
    logic               r_done;
    logic [IDX_W-1:0]   r_idx;
    logic [TMR_W-1:0]   r_timer;
    logic [N_TESTS-1:0] r_ok;
    logic [N_TESTS-1:0] r_to;

    seq_state_e         w_state_nxt;
    logic [N_TESTS-1:0] w_start_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic [N_TESTS-1:0] w_ok_nxt;
    logic [N_TESTS-1:0] w_to_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [N_TESTS-1:0] w_fin_s;
    logic [N_TESTS-1:0] w_cur_bit;
    logic               w_fin_cur;
    logic               w_last_idx;
    logic               w_timer_exp;

    sync_2ff #(
        .W (N_TESTS)
    ) u_fin_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .i_d   (finish),
        .o_q   (w_fin_s)
    );

    assign w_cur_bit   = N_TESTS'(f_onehot(5'(r_idx)));
    assign w_fin_cur   = |(w_fin_s & w_cur_bit);
    assign w_last_idx  = (r_idx == IDX_W'(N_TESTS - 1));
    assign w_timer_exp = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

    // Next-state, launch vector, index, timer and result-mask logic.
    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = r_start;
        w_idx_nxt   = r_idx;
        w_timer_nxt = r_timer;
        w_ok_nxt    = r_ok;
        w_to_nxt    = r_to;
        case (r_state)
            SEQ_IDLE: begin
                if (run) begin
                    w_state_nxt = SEQ_LAUNCH;
                    w_idx_nxt   = '0;
                    w_ok_nxt    = '0;
                    w_to_nxt    = '0;
                end else begin
                    w_state_nxt = SEQ_IDLE;
                end
            end
            SEQ_LAUNCH: begin
                // A finish already high before launch cannot be a real answer.
                if (w_fin_cur) begin
                    w_to_nxt    = r_to | w_cur_bit;
                    w_state_nxt = SEQ_NEXT;
                end else begin
                    w_start_nxt = w_cur_bit;
                    w_timer_nxt = '0;
                    w_state_nxt = SEQ_WAIT;
                end
            end
            SEQ_WAIT: begin
                w_timer_nxt = r_timer + TMR_W'(1);
                if (w_fin_cur) begin
                    w_ok_nxt    = r_ok | w_cur_bit;
                    w_start_nxt = '0;
                    w_state_nxt = SEQ_NEXT;
                end else if (w_timer_exp) begin
                    w_to_nxt    = r_to | w_cur_bit;
                    w_start_nxt = '0;
                    w_state_nxt = SEQ_NEXT;
                end else begin
                    w_state_nxt = SEQ_WAIT;
                end
            end
            SEQ_NEXT: begin
                if (w_last_idx) begin
                    w_state_nxt = SEQ_DONE;
                end else begin
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_state_nxt = SEQ_LAUNCH;
                end
            end
            SEQ_DONE: begin
                if (!run) begin
                    w_state_nxt = SEQ_IDLE;
                end else begin
                    w_state_nxt = SEQ_DONE;
                end
            end
            default: begin
                w_state_nxt = SEQ_IDLE;
                w_start_nxt = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != SEQ_IDLE) && (w_state_nxt != SEQ_DONE);
        w_done_nxt = (w_state_nxt == SEQ_DONE);
    end

    // State, timer, index, mask and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SEQ_IDLE;
            r_start <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= '0;
            r_timer <= '0;
            r_ok    <= '0;
            r_to    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_start_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_idx   <= w_idx_nxt;
            r_timer <= w_timer_nxt;
            r_ok    <= w_ok_nxt;
            r_to    <= w_to_nxt;
        end
    end

    assign start        = r_start;
    assign busy         = r_busy;
    assign done         = r_done;
    assign cur_idx      = r_idx;
    assign ok_mask      = r_ok;
    assign timeout_mask = r_to;

endmodule

// File: tb/tb_unit_test_sequencer.sv
// Self-checking bench for unit_test_sequencer: directed scenarios plus random
// sweeps, compared every cycle against a transaction-level behavioural model.
module tb_unit_test_sequencer;

    localparam int N = 4;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         run = 1'b0;
    logic [N-1:0] finish;
    logic [N-1:0] start;
    logic         busy;
    logic         done;
    logic [1:0]   cur_idx;
    logic [N-1:0] ok_mask;
    logic [N-1:0] timeout_mask;

    int total = 0;
    int bad = 0;

    int           dly [N];
    int           cnt [N];
    int           hi_len [N];
    int           rises [N];
    int           rise_log [$];
    logic [N-1:0] resp_fin = '0;
    logic [N-1:0] force_fin = '0;
    logic [N-1:0] noise = '0;
    logic         noise_en = 1'b0;
    logic [N-1:0] prev_start = '0;

    assign finish = resp_fin | force_fin | noise;

    always #5 clk = ~clk;

    unit_test_sequencer #(
        .N_TESTS        (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .run          (run),
        .finish       (finish),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .cur_idx      (cur_idx),
        .ok_mask      (ok_mask),
        .timeout_mask (timeout_mask)
    );

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_LAUNCH = 1, P_WAIT = 2, P_NEXT = 3, P_DONE = 4;
    int           m_ph = P_IDLE;
    int           m_idx = 0;
    int           m_age = 0;
    logic [N-1:0] m_start = '0, m_ok = '0, m_to = '0;
    logic [N-1:0] m_f1 = '0, m_f2 = '0;

    always @(posedge clk or negedge reset_n) begin : model
        logic fs;
        if (!reset_n) begin
            m_ph = P_IDLE; m_idx = 0; m_age = 0;
            m_start = '0; m_ok = '0; m_to = '0; m_f1 = '0; m_f2 = '0;
        end else begin
            fs = m_f2[m_idx];
            case (m_ph)
                P_IDLE: if (run) begin
                    m_ph = P_LAUNCH; m_idx = 0; m_ok = '0; m_to = '0;
                end
                P_LAUNCH: if (fs) begin
                    m_to[m_idx] = 1'b1; m_ph = P_NEXT;
                end else begin
                    m_start = '0; m_start[m_idx] = 1'b1; m_age = 0; m_ph = P_WAIT;
                end
                P_WAIT: begin
                    m_age++;
                    if (fs) begin
                        m_ok[m_idx] = 1'b1; m_start = '0; m_ph = P_NEXT;
                    end else if (m_age == T) begin
                        m_to[m_idx] = 1'b1; m_start = '0; m_ph = P_NEXT;
                    end
                end
                P_NEXT: if (m_idx == N - 1) m_ph = P_DONE; else begin
                    m_idx++; m_ph = P_LAUNCH;
                end
                default: if (!run) m_ph = P_IDLE;
            endcase
            m_f2 = m_f1;
            m_f1 = finish;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            total++;
            if (start !== m_start || busy !== (m_ph != P_IDLE && m_ph != P_DONE) ||
                done !== (m_ph == P_DONE) || cur_idx !== 2'(m_idx) ||
                ok_mask !== m_ok || timeout_mask !== m_to ||
                $countones(start) > 1 || (ok_mask & timeout_mask) != '0) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t actual start=%b busy=%b done=%b idx=%0d ok=%b to=%b required start=%b ph=%0d idx=%0d ok=%b to=%b",
                         $time, start, busy, done, cur_idx, ok_mask, timeout_mask,
                         m_start, m_ph, m_idx, m_ok, m_to);
            end
        end
    end

    // Responders: raise finish dly cycles after start rises, drop with start.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (start[i]) begin
                cnt[i]++;
                if (dly[i] > 0 && cnt[i] == dly[i]) resp_fin[i] = 1'b1;
            end else begin
                cnt[i] = 0;
                resp_fin[i] = 1'b0;
            end
            if (start[i] && !prev_start[i]) begin
                hi_len[i] = 1; rises[i]++; rise_log.push_back(i);
            end else if (start[i]) begin
                hi_len[i]++;
            end
        end
        prev_start = start;
        if (noise_en) noise[3] = ~noise[3]; else noise = '0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL wait_done actual=timeout required=done");
        end
    endtask

    task automatic wait_start(input int b, input logic lvl, input int budget);
        int k = 0;
        while (start[b] !== lvl && k < budget) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (start[b] !== lvl) begin
            bad++;
            $display("FAIL wait_start%0d actual=%b required=%b", b, start[b], lvl);
        end
    endtask

    task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    endtask

    task automatic sweep(input int hold);
        @(negedge clk);
        run = 1'b1;
        repeat (hold) @(negedge clk);
        run = 1'b0;
        wait_done(300);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int ord, r1, hold;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0; hi_len[i] = 0; rises[i] = 0;
        end
        set_dly(5, 9, 3, 7);
        repeat (3) @(negedge clk);
        chk("reset_start", 32'(start), 32'h0);
        chk("reset_flags", {30'd0, busy, done}, 32'h0);
        chk("reset_masks", {24'd0, ok_mask, timeout_mask}, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: all responders answer
        rise_log.delete();
        sweep(1);
        ord = 0;
        foreach (rise_log[k]) ord = (ord << 4) | rise_log[k];
        chk("rise_order", 32'(ord), 32'h0123);
        chk("s1_ok", 32'(ok_mask), 32'hf);
        chk("s1_to", 32'(timeout_mask), 32'h0);
        chk("s1_model", {24'd0, m_ok, m_to}, 32'hf0);

        // 2: responder 2 hangs
        set_dly(5, 9, 0, 7);
        sweep(1);
        chk("s2_hold_len", 32'(hi_len[2]), 32'd16);
        chk("s2_to", 32'(timeout_mask), 32'h4);
        chk("s2_ok", 32'(ok_mask), 32'hb);

        // 3: stale finish on test 1
        set_dly(5, 9, 3, 7);
        force_fin[1] = 1'b1;
        repeat (3) @(negedge clk);
        r1 = rises[1];
        sweep(1);
        chk("s3_no_start1", 32'(rises[1]), 32'(r1));
        chk("s3_to", 32'(timeout_mask), 32'h2);
        chk("s3_ok", 32'(ok_mask), 32'hd);
        force_fin = '0;
        repeat (4) @(negedge clk);

        // 4: finish coincides with last timer cycle, then one cycle late
        set_dly(14, 2, 2, 2);
        sweep(1);
        chk("s4_edge_ok", {28'd0, ok_mask[0], timeout_mask[0]}, 32'h2);
        set_dly(15, 2, 2, 2);
        sweep(1);
        chk("s4_late_to", {28'd0, ok_mask[0], timeout_mask[0]}, 32'h1);

        // 5: reset mid-sweep while start[2] is high
        set_dly(5, 9, 12, 7);
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
        wait_start(2, 1'b1, 100);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("s5_start_async", 32'(start), 32'h0);
        chk("s5_state", {29'd0, busy, done, |cur_idx}, 32'h0);
        chk("s5_masks", {24'd0, ok_mask, timeout_mask}, 32'h0);
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(negedge clk);
        set_dly(5, 9, 3, 7);
        sweep(1);
        chk("s5_rerun_ok", {24'd0, ok_mask, timeout_mask}, 32'hf0);

        // 6: noise on finish[3] during test 1, run held through DONE
        @(negedge clk) run = 1'b1;
        wait_start(1, 1'b1, 100);
        noise_en = 1'b1;
        wait_start(1, 1'b0, 100);
        noise_en = 1'b0;
        wait_done(300);
        chk("s6_masks", {24'd0, ok_mask, timeout_mask}, 32'hf0);
        repeat (20) @(negedge clk);
        chk("s6_hold_done", {28'd0, done, busy, |start}, 32'h4);
        run = 1'b0;
        repeat (2) @(negedge clk);
        chk("s6_idle", {30'd0, done, busy}, 32'h0);
        run = 1'b1;
        repeat (2) @(negedge clk);
        chk("s6_restart", {31'd0, busy}, 32'h1);
        run = 1'b0;
        wait_done(300);
        repeat (4) @(negedge clk);

        // random sweeps
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < N; i++) dly[i] = $urandom_range(0, 20);
            if ($urandom_range(0, 3) == 0) force_fin[$urandom_range(0, N - 1)] = 1'b1;
            repeat (3) @(negedge clk);
            hold = $urandom_range(1, 3);
            sweep(hold);
            chk("rnd_cover", 32'(ok_mask | timeout_mask), 32'hf);
            force_fin = '0;
            repeat (4) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
